data_mem_resp: RTL and testbench
================================

# data_mem_resp

Word-addressed data memory responder serving the load/store port of the MIPS datapath (byte address, store data, load data). Accepts one access at a time over a req/ack handshake, models a fixed, parameterised access latency through a small state machine, and returns load data registered alongside a one-cycle acknowledge. This is the memory-side end of the datapath's data interface and replaces the zero-latency combinational data memory in multicycle and stall-capable builds.

## Interface
- DEPTH, 256, number of 32-bit words; power of two, 4..65536
- LATENCY, 2, cycles from request acceptance to ack; 1..16

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  1  access request; held high by requester until ack
- we  in  1  1 = store, 0 = load; sampled with req
- addr  in  32  byte address (DataAddr)
- wdata  in  32  store data (WriteMem); sampled with req
- rdata  out  32  load data (Memout); valid while ack=1, held until next load completes
- ack  out  1  one-cycle completion pulse
- busy  out  1  high whenever state != IDLE
- err  out  1  misaligned-access flag, valid with ack (tied 0 without DMEM_ALIGN_CHECK_EN)

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: if req=1 at the clock edge, latch we/addr/wdata. LATENCY=1 -> RESP; else -> WAIT with cnt = LATENCY-2.
- WAIT: cnt != 0 -> decrement, stay; cnt == 0 -> RESP.
- Commit edge = edge entering RESP: store writes latched wdata to mem[idx]; load copies mem[idx] into rdata.
- RESP: ack=1 for exactly this cycle; req ignored; -> IDLE unconditionally.
- idx = latched addr[log2(DEPTH)+1:2]; higher address bits ignored (addresses wrap modulo 4*DEPTH bytes).
- Inputs changing after acceptance have no effect on the in-flight access.
- rdata updates only on load commit; stores leave rdata unchanged.
- Memory array is not reset; contents survive rst.

## Timing
- Reset values: state IDLE, cnt 0, ack 0, busy 0, err 0, rdata 32'h0.
- Request sampled in cycle T (IDLE, req=1) -> ack=1 in cycle T+LATENCY; busy=1 in cycles T+1..T+LATENCY.
- Store visible to a load accepted in any cycle after its ack.
- req held high through ack -> next access accepted in cycle T+LATENCY+1 (the IDLE cycle after RESP); minimum spacing LATENCY+1 cycles.
- req dropped before acceptance -> no access.
- rst asserted at any point -> immediate return to reset values; in-flight access aborted; no ack; store not committed unless its commit edge preceded rst assertion.

## Configuration
- DMEM_ALIGN_CHECK_EN defined: at commit, latched addr[1:0] != 0 suppresses the access (no write, rdata unchanged); ack still pulses with err=1 in the same cycle. Aligned accesses give err=0.
- Not defined: addr[1:0] ignored, misaligned addresses access the containing word, err tied 0.

## Test plan
- LATENCY=2: store 32'hDEADBEEF to 0x10 at T -> ack at T+2 only, busy T+1..T+2; load 0x10 -> rdata 32'hDEADBEEF with ack, held afterwards.
- DEPTH=256: store 32'hA5A5A5A5 to 0x400, load 0x0 -> rdata 32'hA5A5A5A5 (wrap).
- req held continuously for store then load: each ack exactly one cycle; second access accepted at T+3 (LATENCY=2), ack at T+5.
- mem[0x20]=32'h11111111; store 32'h22222222 to 0x20, assert rst during WAIT -> no ack, outputs at reset values; subsequent load 0x20 -> 32'h11111111.
- Store 32'hCAFEF00D to 0x13: with DMEM_ALIGN_CHECK_EN -> err=1 with ack, load 0x10 returns prior value; without it -> err=0, load 0x10 returns 32'hCAFEF00D.
- LATENCY=1: load accepted at T -> ack and rdata valid at T+1, busy only at T+1.

Source files
------------

// File: rtl/data_mem_resp.sv
// Word-addressed data memory responder with req/ack handshake and fixed access latency.
// Optional misaligned-access detection is enabled by defining DMEM_ALIGN_CHECK_EN.
module data_mem_resp #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        busy,
   output logic        err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = 4;
   localparam logic [CW-1:0] CNT_INIT = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;
   logic            accept;
   logic            commit;

   logic            we_p0;
   logic [31:0]     addr_p0;
   logic [31:0]     wdata_p0;

   logic            c_we;
   logic [31:0]     c_addr;
   logic [31:0]     c_wdata;
   logic [AW-1:0]   idx;
   logic            misalign;
   logic            do_write;
   logic            do_load;

   logic [31:0]     mem [DEPTH];

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               accept = 1'b1;
               if (LATENCY == 1) begin
                  state_nxt = RESP;
                  commit    = 1'b1;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else begin
               state_nxt = RESP;
               commit    = 1'b1;
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // With LATENCY=1 the commit edge is also the accept edge, so the live inputs are used.
   assign c_we    = (state == IDLE) ? we    : we_p0;
   assign c_addr  = (state == IDLE) ? addr  : addr_p0;
   assign c_wdata = (state == IDLE) ? wdata : wdata_p0;
   assign idx     = c_addr[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
   assign misalign = |c_addr[1:0];
`else
   assign misalign = 1'b0;
   logic unused_low;
   assign unused_low = ^c_addr[1:0];
`endif

   logic unused_high;
   assign unused_high = ^c_addr[31:AW+2];

   assign do_write = commit & c_we & ~misalign & ~rst;
   assign do_load  = commit & ~c_we & ~misalign;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         rdata <= 32'h0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (do_load) begin
            rdata <= mem[idx];
         end
      end
   end

   // Request capture stage
   always_ff @(posedge clk) begin
      if (accept) begin
         we_p0    <= we;
         addr_p0  <= addr;
         wdata_p0 <= wdata;
      end
   end

   // Storage array is deliberately left out of reset so contents survive rst.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[idx] <= c_wdata;
      end
   end

   assign ack  = (state == RESP);
   assign busy = (state != IDLE);

`ifdef DMEM_ALIGN_CHECK_EN
   logic err_p1;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_p1 <= 1'b0;
      end else if (commit) begin
         err_p1 <= misalign;
      end
   end
   assign err = ack & err_p1;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_resp.sv
// Randomized self-checking bench for data_mem_resp against an array-based reference model.
// A second LATENCY=1 instance covers the single-cycle-latency timing.
module tb_data_mem_resp;

   localparam int DEPTH  = 256;
   localparam int LAT    = 2;
   localparam int DEPTH1 = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req, we;
   logic [31:0] addr, wdata, rdata;
   logic        ack, busy, err;

   logic        req1, we1;
   logic [31:0] addr1, wdata1, rdata1;
   logic        ack1, busy1, err1;

   int tests = 0;
   int fails = 0;

   logic [31:0] model_mem [DEPTH];
   logic [31:0] model_rdata = 32'h0;
   bit          in_resp = 1'b0;

   always #5 clk = ~clk;

   data_mem_resp #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ack(ack), .busy(busy), .err(err)
   );

   data_mem_resp #(.DEPTH(DEPTH1), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
      .rdata(rdata1), .ack(ack1), .busy(busy1), .err(err1)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int unsigned widx(input logic [31:0] a);
      return (a / 4) % DEPTH;
   endfunction

   function automatic bit misaligned(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
      return (a % 4) != 0;
`else
      return 1'b0;
`endif
   endfunction

   // One complete access; drop=0 keeps req high so the next call runs back-to-back.
   task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input bit drop);
      bit exp_err;
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d;
      if (in_resp) begin
         @(posedge clk); #1;
         check_val("b2b_idle_ack", 32'(ack), 32'd0);
         check_val("b2b_idle_busy", 32'(busy), 32'd0);
         in_resp = 1'b0;
      end else begin
         check_val("pre_busy", 32'(busy), 32'd0);
      end
      exp_err = misaligned(a);
      if (!exp_err) begin
         if (w) model_mem[widx(a)] = d;
         else   model_rdata = model_mem[widx(a)];
      end
      for (int k = 1; k <= LAT; k++) begin
         @(posedge clk); #1;
         check_val("ack_timing", 32'(ack), 32'(k == LAT));
         check_val("busy", 32'(busy), 32'd1);
         if (k == LAT) begin
            check_val("rdata_at_ack", rdata, model_rdata);
            check_val("err_at_ack", 32'(err), 32'(exp_err));
         end
         we = 1'($urandom); addr = $urandom; wdata = $urandom;
      end
      if (drop) begin
         @(negedge clk);
         req = 1'b0;
         @(posedge clk); #1;
         check_val("post_ack", 32'(ack), 32'd0);
         check_val("post_busy", 32'(busy), 32'd0);
         check_val("rdata_held", rdata, model_rdata);
         in_resp = 1'b0;
      end else begin
         in_resp = 1'b1;
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom;
         @(posedge clk); #1;
         check_val("idle_busy", 32'(busy), 32'd0);
         check_val("idle_ack", 32'(ack), 32'd0);
      end
      in_resp = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] v;
      req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;

      #2 rst = 1'b1;
      #1;
      check_val("rst_rdata", rdata, 32'h0);
      check_val("rst_ack", 32'(ack), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_err", 32'(err), 32'd0);
      check_val("rst_rdata1", rdata1, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < DEPTH; i++)
         access(1'b1, 32'(i * 4), $urandom, bit'($urandom_range(0, 1)));
      idle_cycles(1);

      access(1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
      access(1'b0, 32'h10, 32'h0, 1'b1);
      check_val("deadbeef", rdata, 32'hDEADBEEF);

      access(1'b1, 32'h400, 32'hA5A5A5A5, 1'b1);
      access(1'b0, 32'h0, 32'h0, 1'b1);
      check_val("wrap", rdata, 32'hA5A5A5A5);

      access(1'b1, 32'h30, 32'h12345678, 1'b0);
      access(1'b0, 32'h30, 32'h0, 1'b1);
      check_val("b2b_load", rdata, 32'h12345678);

      access(1'b1, 32'h20, 32'h11111111, 1'b1);
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h22222222;
      @(posedge clk); #1;
      check_val("abort_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check_val("abort_rdata", rdata, 32'h0);
      check_val("abort_ack", 32'(ack), 32'd0);
      check_val("abort_busy_rst", 32'(busy), 32'd0);
      check_val("abort_err", 32'(err), 32'd0);
      model_rdata = 32'h0;
      @(negedge clk) req = 1'b0;
      @(posedge clk); #1;
      check_val("abort_no_ack", 32'(ack), 32'd0);
      @(negedge clk) rst = 1'b0;
      access(1'b0, 32'h20, 32'h0, 1'b1);
      check_val("abort_mem", rdata, 32'h11111111);

      access(1'b0, 32'h10, 32'h0, 1'b1);
      v = rdata;
      access(1'b1, 32'h13, 32'hCAFEF00D, 1'b1);
      access(1'b0, 32'h10, 32'h0, 1'b1);
`ifdef DMEM_ALIGN_CHECK_EN
      check_val("misalign_load", rdata, v);
`else
      check_val("misalign_load", rdata, 32'hCAFEF00D);
`endif

      for (int i = 0; i < 300; i++) begin
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         access(1'($urandom), a, $urandom, bit'($urandom_range(0, 1)));
         if ($urandom_range(0, 7) == 0) idle_cycles($urandom_range(1, 3));
      end
      idle_cycles(2);

      v = $urandom;
      @(negedge clk);
      check_val("l1_pre_busy", 32'(busy1), 32'd0);
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h4; wdata1 = v;
      @(posedge clk); #1;
      check_val("l1_st_ack", 32'(ack1), 32'd1);
      check_val("l1_st_busy", 32'(busy1), 32'd1);
      check_val("l1_st_rdata", rdata1, 32'h0);
      @(negedge clk) req1 = 1'b0;
      @(posedge clk); #1;
      check_val("l1_st_post_ack", 32'(ack1), 32'd0);
      check_val("l1_st_post_busy", 32'(busy1), 32'd0);
      @(negedge clk);
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h4 + 32'(DEPTH1 * 4);
      @(posedge clk); #1;
      check_val("l1_ld_ack", 32'(ack1), 32'd1);
      check_val("l1_ld_busy", 32'(busy1), 32'd1);
      check_val("l1_ld_rdata", rdata1, v);
      check_val("l1_ld_err", 32'(err1), 32'd0);
      @(negedge clk) req1 = 1'b0;
      @(posedge clk); #1;
      check_val("l1_ld_post_ack", 32'(ack1), 32'd0);
      check_val("l1_ld_post_busy", 32'(busy1), 32'd0);
      check_val("l1_ld_held", rdata1, v);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
